// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between the core's memory port and mem_responder.
// master = requester (datapath side), slave = responder (memory side).
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [3:0]            req_wstrb;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: unified instruction/data word memory behind a valid/ready
// request/response handshake, one outstanding request, fixed access latency.
// Optional feature macro: MEM_WSTRB_EN (byte-enabled stores via req_wstrb).
// mem[] is not reset; testbenches preload it hierarchically.
module mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      cnt;

  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_wdata;
`ifdef MEM_WSTRB_EN
  logic [3:0]            lat_wstrb;
  logic [3:0]            a_wstrb;
`endif

  logic [31:0]           mem [DEPTH_WORDS];

  logic                  accept;
  logic                  access;
  logic                  a_write;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [31:0]           a_wdata;
  logic [IDX_W-1:0]      a_idx;
  logic [MEM_AW-1:0]     a_mem_idx;
  logic                  a_err;
  logic                  mem_we;

  logic [31:0]           rdata_q;
  logic                  err_q;

  // Access qualification: with LATENCY==1 the access happens on the accept edge itself,
  // so the operands come straight from the bus instead of the latched copy.
  always_comb begin
    accept  = (state == IDLE) && bus.req_valid;
    if (LATENCY == 1) begin
      access  = accept;
      a_write = bus.req_write;
      a_addr  = bus.req_addr;
      a_wdata = bus.req_wdata;
`ifdef MEM_WSTRB_EN
      a_wstrb = bus.req_wstrb;
`endif
    end else begin
      access  = (state == WAIT) && (cnt == CNT_W'(1));
      a_write = lat_write;
      a_addr  = lat_addr;
      a_wdata = lat_wdata;
`ifdef MEM_WSTRB_EN
      a_wstrb = lat_wstrb;
`endif
    end
    a_idx     = a_addr[ADDR_WIDTH-1:2];
    a_mem_idx = a_idx[MEM_AW-1:0];
    a_err     = (a_addr[1:0] != 2'b00) || (64'(a_idx) >= 64'(DEPTH_WORDS));
    mem_we    = access && a_write && !a_err && !reset;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: IDLE -> WAIT -> RESP -> IDLE (WAIT skipped when LATENCY==1).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == CNT_W'(1)) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // Request latch, latency counter and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
`ifdef MEM_WSTRB_EN
      lat_wstrb <= '0;
`endif
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        lat_write <= bus.req_write;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
`ifdef MEM_WSTRB_EN
        lat_wstrb <= bus.req_wstrb;
`endif
        cnt       <= CNT_W'(LATENCY - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
      end
      if (access) begin
        err_q   <= a_err;
        rdata_q <= (a_write || a_err) ? '0 : mem[a_mem_idx];
      end else if ((state == RESP) && bus.rsp_ready) begin
        err_q <= 1'b0;
      end
    end
  end

  // Store commit; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
`ifdef MEM_WSTRB_EN
      for (int unsigned i = 0; i < 4; i++) begin
        if (a_wstrb[i]) mem[a_mem_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
`else
      mem[a_mem_idx] <= a_wdata;
`endif
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a table of directed single transactions
// plus hand-written sequences for back-pressure and reset corner cases.
module tb_mem_responder;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_WIDTH(32)) bus ();

  mem_responder #(
    .ADDR_WIDTH (32),
    .DEPTH_WORDS(1024),
    .LATENCY    (LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] er, input logic ee,
                        input string tag);
    int guard;
    int lat;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_wstrb = ws;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(LAT));
    chk({tag, " rdata"}, bus.rsp_rdata, er);
    chk({tag, " err"}, 32'(bus.rsp_err), 32'(ee));
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({tag, " rsp_valid drop"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, " req_ready back"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_strb;
    int          guard;
`ifdef MEM_WSTRB_EN
    exp_strb = 32'h11BB_33DD;
`else
    exp_strb = 32'hAABB_CCDD;
`endif
    //           write  addr           wdata          wstrb    exp_rdata      exp_err
    vecs[0]  = '{1'b0, 32'h0000_0018, 32'h0,         4'hF,    32'h0000_0019, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0018, 32'hDEAD_BEEF, 4'hF,    32'h0,         1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0018, 32'h0,         4'hF,    32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_001A, 32'h0,         4'hF,    32'h0,         1'b1};
    vecs[4]  = '{1'b0, 32'h0000_1000, 32'h0,         4'hF,    32'h0,         1'b1};
    vecs[5]  = '{1'b1, 32'h0000_001A, 32'h0000_0001, 4'hF,    32'h0,         1'b1};
    vecs[6]  = '{1'b1, 32'h0000_1000, 32'h0000_0077, 4'hF,    32'h0,         1'b1};
    vecs[7]  = '{1'b1, 32'h8000_0018, 32'h0000_0055, 4'hF,    32'h0,         1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0018, 32'h0,         4'hF,    32'hDEAD_BEEF, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0FFC, 32'h0,         4'hF,    32'h5A5A_A5A5, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF,    32'h0,         1'b0};
    vecs[11] = '{1'b1, 32'h0000_0008, 32'hAABB_CCDD, 4'b0101, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 32'h0000_0008, 32'h0,         4'hF,    exp_strb,      1'b0};
    vecs[13] = '{1'b0, 32'h0000_0004, 32'h0,         4'hF,    32'h0BAD_F00D, 1'b0};

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);

    dut.mem[0]    = 32'h0;
    dut.mem[1]    = 32'h0BAD_F00D;
    dut.mem[2]    = 32'h1122_3344;
    dut.mem[6]    = 32'h0000_0019;
    dut.mem[8]    = 32'hCAFE_0001;
    dut.mem[1023] = 32'h5A5A_A5A5;

    for (int i = 0; i < 14; i++) begin
      do_req(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
             vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // Back-pressure: response held 5 cycles, competing request ignored.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0000_0018;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    guard = 0;
    while (!bus.rsp_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h0000_0018;
    bus.req_wdata = 32'h0000_0BAD;
    bus.req_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d rsp_valid", i), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("hold%0d rdata", i), bus.rsp_rdata, 32'hDEAD_BEEF);
      chk($sformatf("hold%0d req_ready", i), 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("hold release rsp_valid", 32'(bus.rsp_valid), 32'd0);
    do_req(1'b0, 32'h0000_0018, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, "after hold");

    // Reset while a store sits in WAIT: the store must never commit.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h0000_0020;
    bus.req_wdata = 32'h0000_1234;
    bus.req_wstrb = 4'hF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("midwait in WAIT", 32'(bus.req_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midwait req_ready", 32'(bus.req_ready), 32'd1);
    chk("midwait rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midwait no late rsp", 32'(bus.rsp_valid), 32'd0);
    chk("midwait mem8", dut.mem[8], 32'hCAFE_0001);
    do_req(1'b0, 32'h0000_0020, 32'h0, 4'hF, 32'hCAFE_0001, 1'b0, "midwait read");

    // Reset dominates a same-edge response handshake.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0000_001A;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    guard = 0;
    while (!bus.rsp_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("rspreset err before", 32'(bus.rsp_err), 32'd1);
    bus.rsp_ready = 1'b1;
    reset         = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    reset         = 1'b0;
    chk("rspreset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rspreset rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rspreset req_ready", 32'(bus.req_ready), 32'd1);

    // Reset dominates a same-edge request accept.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h0000_0018;
    bus.req_wdata = 32'h0000_0BAD;
    reset         = 1'b1;
    @(posedge clk); #1;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    chk("reqreset req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    chk("reqreset still idle", 32'(bus.req_ready), 32'd1);
    chk("reqreset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    do_req(1'b0, 32'h0000_0018, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, "reqreset read");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
